// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment table, blank pattern and index-width helper for seg_scan_driver
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // {ca..cg}, active-low; listed F down to 0 so SEG_TABLE[n] is the pattern for nibble n
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
      7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
      7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
      7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
   };

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_scan_driver_decoder.sv
// rtl/seg_scan_driver_decoder.sv - combinational table-driven hex to seven-segment decoder
module hex_segment_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_TABLE[nibble];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed N-digit seven-segment driver with frame-aligned double buffering
// Define SEG_LZ_BLANK_EN to suppress leading zeros on the displayed value.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter bit ACTIVE_LOW_AN = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     blank_mask,
   output logic                  ca,
   output logic                  cb,
   output logic                  cc,
   output logic                  cd,
   output logic                  ce,
   output logic                  cf,
   output logic                  cg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done,
   output logic                  applied
);

   localparam int IW = idx_width(DIGITS);
   localparam int CW = idx_width(REFRESH_DIV);
   localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
   localparam logic [CW-1:0]     LAST_CNT = CW'(REFRESH_DIV - 1);
   localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW_AN}};

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
   logic                pending_q, pending_d;
   logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
   logic [DIGITS-1:0]   disp_mask_q, disp_mask_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_done_q, frame_done_d;
   logic                applied_q, applied_d;

   logic                tick;
   logic                wrap;
   logic [DIGITS-1:0]   eff_blank;
   logic [DIGITS-1:0]   an_act;
   logic [3:0]          nibble;
   logic [6:0]          dec_seg;

   always_comb begin
      eff_blank = disp_mask_q;
`ifdef SEG_LZ_BLANK_EN
      begin
         logic higher_ok;
         higher_ok = 1'b1;
         // digit 0 is excluded so an all-zero value still shows one "0"
         for (int i = DIGITS - 1; i > 0; i--) begin
            if (higher_ok && disp_val_q[4*i +: 4] == 4'h0) begin
               eff_blank[i] = 1'b1;
            end
            higher_ok = higher_ok && (disp_val_q[4*i +: 4] == 4'h0 || disp_mask_q[i]);
         end
      end
`endif
   end

   always_comb begin
      nibble = disp_val_q[{idx_q, 2'b00} +: 4];
   end

   hex_segment_decoder u_dec (
      .nibble (nibble),
      .seg    (dec_seg)
   );

   always_comb begin
      tick = (cnt_q == LAST_CNT);
      wrap = tick && (idx_q == LAST_IDX);

      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
      end

      shadow_val_d  = shadow_val_q;
      shadow_mask_d = shadow_mask_q;
      pending_d     = pending_q;
      disp_val_d    = disp_val_q;
      disp_mask_d   = disp_mask_q;
      applied_d     = 1'b0;

      // the display register only moves on the wrap tick, so a scan never mixes frames
      if (wrap && load) begin
         disp_val_d  = value;
         disp_mask_d = blank_mask;
         pending_d   = 1'b0;
         applied_d   = 1'b1;
      end else if (wrap && pending_q) begin
         disp_val_d  = shadow_val_q;
         disp_mask_d = shadow_mask_q;
         pending_d   = 1'b0;
         applied_d   = 1'b1;
      end else if (load) begin
         shadow_val_d  = value;
         shadow_mask_d = blank_mask;
         pending_d     = 1'b1;
      end

      frame_done_d = wrap;

      // first cycle of each slot is dead time so the previous digit cannot ghost
      an_act = '0;
      if (cnt_q != '0 && !eff_blank[idx_q]) begin
         an_act[idx_q] = 1'b1;
      end
      an_d  = ACTIVE_LOW_AN ? ~an_act : an_act;
      seg_d = eff_blank[idx_q] ? SEG_OFF : dec_seg;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_val_q  <= '0;
         shadow_mask_q <= '1;
         pending_q     <= 1'b0;
         disp_val_q    <= '0;
         disp_mask_q   <= '1;
         seg_q         <= SEG_OFF;
         an_q          <= AN_OFF;
         frame_done_q  <= 1'b0;
         applied_q     <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_val_q  <= shadow_val_d;
         shadow_mask_q <= shadow_mask_d;
         pending_q     <= pending_d;
         disp_val_q    <= disp_val_d;
         disp_mask_q   <= disp_mask_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_done_q  <= frame_done_d;
         applied_q     <= applied_d;
      end
   end

   assign {ca, cb, cc, cd, ce, cf, cg} = seg_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;
   assign applied    = applied_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver (DIGITS=4, REFRESH_DIV=4)
module tb_seg_scan_driver;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  blank_mask;
   logic        ca, cb, cc, cd, ce, cf, cg;
   logic [3:0]  an;
   logic        frame_done;
   logic        applied;
   logic [6:0]  seg_bus;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   assign seg_bus = {ca, cb, cc, cd, ce, cf, cg};

   seg_scan_driver #(
      .DIGITS        (4),
      .REFRESH_DIV   (4),
      .ACTIVE_LOW_AN (1'b1)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .value      (value),
      .blank_mask (blank_mask),
      .ca         (ca),
      .cb         (cb),
      .cc         (cc),
      .cd         (cd),
      .ce         (ce),
      .cf         (cf),
      .cg         (cg),
      .an         (an),
      .frame_done (frame_done),
      .applied    (applied)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic logic ref_blank(input logic [15:0] v, input logic [3:0] m, input int d);
      logic lz;
      lz = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      if (d != 0 && v[4*d +: 4] == 4'h0) begin
         lz = 1'b1;
         for (int j = d + 1; j < 4; j++) begin
            if (v[4*j +: 4] != 4'h0 && !m[j]) lz = 1'b0;
         end
      end
`endif
      return m[d] | lz;
   endfunction

   task automatic wait_frame();
      int i;
      i = 0;
      do begin
         @(negedge clock);
         i++;
      end while (!frame_done && i < 40);
      check_eq("frame_wait", {15'b0, frame_done}, 16'd1);
   endtask

   // Checks the 16 samples of one frame; sample 16 is the next wrap. Loads are driven after sample l1/l2.
   task automatic check_frame(input int fid, input logic [15:0] ev, input logic [3:0] em,
                              input logic exp_app,
                              input int l1, input logic [15:0] v1, input logic [3:0] m1,
                              input int l2, input logic [15:0] v2, input logic [3:0] m2);
      int         pos, d, k;
      logic       blk;
      logic [6:0] exp_seg;
      logic [3:0] exp_an;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clock);
         pos     = j - 1;
         d       = pos / 4;
         k       = pos % 4;
         blk     = ref_blank(ev, em, d);
         exp_seg = blk ? 7'h7F : ref_seg(ev[4*d +: 4]);
         exp_an  = (k == 0 || blk) ? 4'hF : ~(4'b0001 << d);
         check_eq($sformatf("f%0d_p%0d_seg", fid, pos), {9'b0, seg_bus}, {9'b0, exp_seg});
         check_eq($sformatf("f%0d_p%0d_an", fid, pos), {12'b0, an}, {12'b0, exp_an});
         check_eq($sformatf("f%0d_p%0d_frame_done", fid, pos), {15'b0, frame_done}, {15'b0, (j == 16)});
         check_eq($sformatf("f%0d_p%0d_applied", fid, pos), {15'b0, applied},
                  {15'b0, (j == 16) ? exp_app : 1'b0});
         load = 1'b0;
         if (j == l1) begin
            load = 1'b1; value = v1; blank_mask = m1;
         end
         if (j == l2) begin
            load = 1'b1; value = v2; blank_mask = m2;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      load       = 1'b0;
      value      = 16'h0000;
      blank_mask = 4'h0;
      repeat (3) @(negedge clock);
      check_eq("rst_seg", {9'b0, seg_bus}, 16'h007F);
      check_eq("rst_an", {12'b0, an}, 16'h000F);
      check_eq("rst_frame_done", {15'b0, frame_done}, 16'd0);
      check_eq("rst_applied", {15'b0, applied}, 16'd0);
      reset_n = 1'b1;

      wait_frame();
      check_eq("first_wrap_applied", {15'b0, applied}, 16'd0);

      check_frame(1, 16'h0000, 4'hF, 1'b1, 5, 16'h1234, 4'h0, 0, 16'h0, 4'h0);
      check_frame(2, 16'h1234, 4'h0, 1'b1, 3, 16'hAAAA, 4'h0, 5, 16'h00F0, 4'h0);
      check_frame(3, 16'h00F0, 4'h0, 1'b1, 15, 16'h8888, 4'h0, 0, 16'h0, 4'h0);
      check_frame(4, 16'h8888, 4'h0, 1'b1, 2, 16'h1234, 4'b0100, 0, 16'h0, 4'h0);
      check_frame(5, 16'h1234, 4'b0100, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

      @(negedge clock);
      @(negedge clock);
      check_eq("pre_reset_an", {12'b0, an}, 16'h000E);
      #1 reset_n = 1'b0;
      #1;
      check_eq("async_rst_seg", {9'b0, seg_bus}, 16'h007F);
      check_eq("async_rst_an", {12'b0, an}, 16'h000F);
      check_eq("async_rst_frame_done", {15'b0, frame_done}, 16'd0);
      check_eq("async_rst_applied", {15'b0, applied}, 16'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      wait_frame();
      check_eq("post_reset_wrap_applied", {15'b0, applied}, 16'd0);
      check_frame(6, 16'h0000, 4'hF, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

`ifdef SEG_LZ_BLANK_EN
      check_frame(7, 16'h0000, 4'hF, 1'b1, 5, 16'h0050, 4'h0, 0, 16'h0, 4'h0);
      check_frame(8, 16'h0050, 4'h0, 1'b1, 5, 16'h0000, 4'h0, 0, 16'h0, 4'h0);
      check_frame(9, 16'h0000, 4'h0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
